// File: rtl/led_level_meter.sv
// Registered LED bar-graph converter: B follows floor(A/4) one cycle later.
// Optional peak-hold fall-off decay is enabled by defining LEDCOUNT_FALLOFF_EN.
module led_level_meter #(
  parameter int DECAY_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] A,
  output logic [3:0] B
);

  logic [3:0] target;
  logic [3:0] b_reg;

  // The two low bits of A are deliberately truncated away.
  assign target = A[5:2];
  assign B      = b_reg;

  logic unused_lsbs;
  assign unused_lsbs = ^A[1:0];

`ifdef LEDCOUNT_FALLOFF_EN

  localparam logic [7:0] DECAY_LAST = 8'(DECAY_CYCLES - 1);

  logic [7:0] decay_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      b_reg         <= 4'd0;
      decay_cnt_reg <= 8'd0;
    end else if (target >= b_reg) begin
      b_reg         <= target;
      decay_cnt_reg <= 8'd0;
    end else if (decay_cnt_reg == DECAY_LAST) begin
      // target < b_reg here, so b_reg >= 1 and b_reg-1 >= target: no wrap.
      b_reg         <= b_reg - 4'd1;
      decay_cnt_reg <= 8'd0;
    end else begin
      decay_cnt_reg <= decay_cnt_reg + 8'd1;
    end
  end

`else

  localparam int unused_decay_cycles = DECAY_CYCLES;

  always_ff @(posedge clk) begin
    if (reset) begin
      b_reg <= 4'd0;
    end else begin
      b_reg <= target;
    end
  end

`endif

endmodule

// File: tb/tb_led_level_meter.sv
// Self-checking bench for led_level_meter; covers base and fall-off builds
// (LEDCOUNT_FALLOFF_EN) with directed scenarios plus randomized tracking.
module tb_led_level_meter;

  localparam int DECAY = 4;

  logic       clk;
  logic       reset;
  logic [5:0] A;
  logic [3:0] B;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: expected B, edge counter, edge of last attack/reset.
  int m_b     = 0;
  int edge_n  = 0;
  int m_ref   = 0;

  led_level_meter #(.DECAY_CYCLES(DECAY)) dut (
    .clk   (clk),
    .reset (reset),
    .A     (A),
    .B     (B)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs, take one rising edge, advance the model, settle 1ns past edge.
  task automatic step(input int a, input bit rst);
    int t;
    A     = 6'(a);
    reset = rst;
    @(posedge clk);
    edge_n++;
    t = a / 4;
    if (rst) begin
      m_b   = 0;
      m_ref = edge_n;
    end else begin
`ifdef LEDCOUNT_FALLOFF_EN
      if (t >= m_b) begin
        m_b   = t;
        m_ref = edge_n;
      end else if (((edge_n - m_ref) % DECAY) == 0) begin
        m_b = m_b - 1;
      end
`else
      m_b = t;
`endif
    end
    #1;
  endtask

  task automatic test_reset;
    step(44, 1'b1);
    step(44, 1'b1);
    n_tests++;
    if (B !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_hold: B=%0d expected=0", B);
    end
    step(44, 1'b0);
    n_tests++;
    if (B !== 4'd11) begin
      n_fail++;
      $display("FAIL reset_release: B=%0d expected=11", B);
    end
    $display("[TB] reset: B=%0d after release", B);
  endtask

  task automatic test_ramp;
    step(0, 1'b1);
    for (int i = 0; i <= 11; i++) begin
      step(i * 4, 1'b0);
      n_tests++;
      if (B !== 4'(i)) begin
        n_fail++;
        $display("FAIL ramp_%0d: B=%0d expected=%0d", i, B, i);
      end
      $display("[TB] ramp A=%0d B=%0d", i * 4, B);
    end
    step(63, 1'b0);
    n_tests++;
    if (B !== 4'd15) begin
      n_fail++;
      $display("FAIL ramp_max: B=%0d expected=15", B);
    end
    step(0, 1'b1);
    step(3, 1'b0);
    n_tests++;
    if (B !== 4'd0) begin
      n_fail++;
      $display("FAIL ramp_a3: B=%0d expected=0", B);
    end
  endtask

  task automatic test_truncation;
    int av [4] = '{5, 6, 7, 8};
    int bv [4] = '{1, 1, 1, 2};
    step(0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(av[i], 1'b0);
      n_tests++;
      if (B !== 4'(bv[i])) begin
        n_fail++;
        $display("FAIL trunc_a%0d: B=%0d expected=%0d", av[i], B, bv[i]);
      end
      $display("[TB] trunc A=%0d B=%0d", av[i], B);
    end
  endtask

  task automatic test_falloff;
    int exp_b;
    step(0, 1'b1);
    step(44, 1'b0);
    step(44, 1'b0);
    for (int k = 1; k <= 11 * DECAY + 8; k++) begin
      step(0, 1'b0);
`ifdef LEDCOUNT_FALLOFF_EN
      exp_b = 11 - (k / DECAY);
      if (exp_b < 0) exp_b = 0;
`else
      exp_b = 0;
`endif
      n_tests++;
      if (B !== 4'(exp_b) || B !== 4'(m_b)) begin
        n_fail++;
        $display("FAIL falloff_k%0d: B=%0d expected=%0d model=%0d", k, B, exp_b, m_b);
      end
    end
    $display("[TB] falloff: final B=%0d", B);
  endtask

  task automatic test_reattack;
    int exp_b;
    step(0, 1'b1);
    step(44, 1'b0);
    for (int k = 0; k < 4 * DECAY; k++) step(0, 1'b0);
`ifdef LEDCOUNT_FALLOFF_EN
    n_tests++;
    if (B !== 4'd7) begin
      n_fail++;
      $display("FAIL reattack_pre: B=%0d expected=7", B);
    end
`endif
    step(40, 1'b0);
    n_tests++;
    if (B !== 4'd10) begin
      n_fail++;
      $display("FAIL reattack_rise: B=%0d expected=10", B);
    end
    for (int k = 1; k <= DECAY; k++) begin
      step(0, 1'b0);
`ifdef LEDCOUNT_FALLOFF_EN
      exp_b = (k < DECAY) ? 10 : 9;
`else
      exp_b = 0;
`endif
      n_tests++;
      if (B !== 4'(exp_b)) begin
        n_fail++;
        $display("FAIL reattack_k%0d: B=%0d expected=%0d", k, B, exp_b);
      end
    end
    $display("[TB] reattack: B=%0d", B);
  endtask

  task automatic test_reset_mid_decay;
    step(0, 1'b1);
    step(44, 1'b0);
    for (int k = 0; k < 5 * DECAY; k++) step(0, 1'b0);
`ifdef LEDCOUNT_FALLOFF_EN
    n_tests++;
    if (B !== 4'd6) begin
      n_fail++;
      $display("FAIL middecay_pre: B=%0d expected=6", B);
    end
`endif
    step(0, 1'b1);
    n_tests++;
    if (B !== 4'd0) begin
      n_fail++;
      $display("FAIL middecay_reset: B=%0d expected=0", B);
    end
    step(20, 1'b0);
    n_tests++;
    if (B !== 4'd5) begin
      n_fail++;
      $display("FAIL middecay_resume: B=%0d expected=5", B);
    end
    $display("[TB] reset mid-decay: B=%0d", B);
  endtask

  task automatic test_random;
    int a;
    bit r;
    a = 0;
    for (int i = 0; i < 400; i++) begin
      // Hold the level most of the time so decay sequences get exercised.
      if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 63);
      r = ($urandom_range(0, 63) == 0);
      step(a, r);
      n_tests++;
      if (B !== 4'(m_b)) begin
        n_fail++;
        $display("FAIL random_%0d: A=%0d reset=%0d B=%0d expected=%0d", i, a, r, B, m_b);
      end
    end
    $display("[TB] random: 400 cycles done");
  endtask

  initial begin
    reset = 1'b1;
    A     = 6'd0;
    test_reset();
    test_ramp();
    test_truncation();
    test_falloff();
    test_reattack();
    test_reset_mid_decay();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
